// File: rtl/adder_arbiter_2req_pkg.sv
// Shared definitions for the two-requester adder arbiter.
//   state_e     : controller states (IDLE, CALC, RESP)
//   WIDTH       : operand/sum width, fixed by the shared half_adder_4_bit
//   REQ0 / REQ1 : requester IDs as they appear on rsp_id
package adder_arb_pkg;

    localparam int unsigned WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder_arbiter_2req_if.sv
// Handshake bundle between two operand producers, one response consumer and the arbiter.
//   req0_*/req1_* : operand channels (valid/ready, operands a and b)
//   rsp_*         : response channel (valid/ready, id, sum, carry)
// Modports:
//   slave  : the arbiter side (accepts operands, produces responses)
//   master : the producer/consumer side
interface adder_arbiter_2req_if;
    import adder_arb_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_carry;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_carry,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_carry,
        output rsp_ready
    );

endinterface

// File: rtl/half_adder_4_bit.sv
// Shared 4-bit datapath: unsigned add without carry-in.
//   a, b : operands
//   s    : (a + b) mod 16
//   c    : carry out (bit 4 of a + b)
module half_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s,
    output logic       c
);

    assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter_2req.sv
// Round-robin arbiter sharing one half_adder_4_bit between two requesters.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : adder_arbiter_2req_if.slave (two operand channels, one response channel)
// A transaction is IDLE (handshake) -> CALC (adder evaluates latched operands) -> RESP
// (registered response held until rsp_ready).
module adder_arbiter_2req
    import adder_arb_pkg::*;
#(
    parameter int unsigned WIDTH = adder_arb_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_arbiter_2req_if.slave  bus
);

    if (WIDTH != 4) begin : g_width_check
        $error("adder_arbiter_2req: WIDTH must be 4 to match half_adder_4_bit");
    end

    state_e     state_q;
    logic       rr_ptr_q;
    logic       gnt_id_q;
    logic [3:0] op_a_q;
    logic [3:0] op_b_q;
    logic       rsp_valid_q;
    logic       rsp_id_q;
    logic [3:0] rsp_sum_q;
    logic       rsp_carry_q;

    logic       gnt_id;
    logic       accept;
    logic [3:0] add_s;
    logic       add_c;

    // Contention goes to rr_ptr; otherwise whoever is valid (req1 only if it is alone).
    // Ready is held low during reset so nothing is accepted while rst is high.
    always_comb begin
        gnt_id         = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
        bus.req0_ready = !rst && (state_q == IDLE) && bus.req0_valid && (gnt_id == REQ0);
        bus.req1_ready = !rst && (state_q == IDLE) && bus.req1_valid && (gnt_id == REQ1);
        accept         = bus.req0_ready || bus.req1_ready;
    end

    half_adder_4_bit u_adder (
        .a (op_a_q),
        .b (op_b_q),
        .s (add_s),
        .c (add_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= REQ0;
            gnt_id_q    <= REQ0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q   <= (gnt_id == REQ1) ? bus.req1_a : bus.req0_a;
                        op_b_q   <= (gnt_id == REQ1) ? bus.req1_b : bus.req0_b;
                        gnt_id_q <= gnt_id;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum_q   <= add_s;
                    rsp_carry_q <= add_c;
                    rsp_id_q    <= gnt_id_q;
                    rsp_valid_q <= 1'b1;
                    // The requester just served loses priority on the next tie.
                    rr_ptr_q    <= ~gnt_id_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        // Response fields return to 0 so idle outputs are all-zero.
                        rsp_valid_q <= 1'b0;
                        rsp_id_q    <= 1'b0;
                        rsp_sum_q   <= '0;
                        rsp_carry_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_adder_arbiter_2req.sv
// Self-checking bench for adder_arbiter_2req: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model (one outstanding request,
// tie-break toward the requester not served last, response two cycles after accept).
module tb_adder_arbiter_2req;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adder_arbiter_2req_if bus ();

    adder_arbiter_2req #(
        .WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       id;
        logic [3:0] sum;
        logic       carry;
    } rsp_t;

    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    rsp_t exp_q[$];
    bit   busy;
    int   lat;
    bit   prefer;

    // Per-cycle observations for the scenarios
    bit   acc0, acc1;
    bit   rsp_hs;
    rsp_t rsp_obs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        busy   = 1'b0;
        lat    = 0;
        prefer = 1'b0;
        exp_q.delete();
    endtask

    // Called at posedge+1 with inputs already driven; checks, advances model, ends at next posedge+1.
    task automatic step();
        logic       e0, e1, ev;
        logic [4:0] total;
        rsp_t       nx;
        #1;
        e0 = !rst && !busy && bus.req0_valid && (!bus.req1_valid || !prefer);
        e1 = !rst && !busy && bus.req1_valid && (!bus.req0_valid || prefer);
        chk("req0_ready", bus.req0_ready, e0);
        chk("req1_ready", bus.req1_ready, e1);
        ev = busy && (lat >= 1);
        chk("rsp_valid", bus.rsp_valid, ev);
        if (ev && exp_q.size() > 0) begin
            chk("rsp_id", bus.rsp_id, exp_q[0].id);
            chk("rsp_sum", bus.rsp_sum, exp_q[0].sum);
            chk("rsp_carry", bus.rsp_carry, exp_q[0].carry);
        end else begin
            chk("rsp_idle_zero", {bus.rsp_id, bus.rsp_sum, bus.rsp_carry}, 0);
        end
        rsp_hs  = ev && bus.rsp_ready;
        rsp_obs = '{id: bus.rsp_id, sum: bus.rsp_sum, carry: bus.rsp_carry};
        if (rsp_hs) begin
            busy = 1'b0;
            void'(exp_q.pop_front());
        end else if (busy) begin
            lat = 1;
        end
        acc0 = e0;
        acc1 = e1;
        if (e0 || e1) begin
            total = e1 ? ({1'b0, bus.req1_a} + {1'b0, bus.req1_b})
                       : ({1'b0, bus.req0_a} + {1'b0, bus.req0_b});
            nx = '{id: e1, sum: total[3:0], carry: total[4]};
            exp_q.push_back(nx);
            busy   = 1'b1;
            lat    = 0;
            prefer = !e1;
        end
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from a single requester, bounded waits.
    task automatic single(input bit id, input logic [3:0] a, input logic [3:0] b);
        int n;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!(acc0 || acc1) && n < 20);
        chk("accept_in_time", (acc0 || acc1), 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!rsp_hs && n < 20);
        chk("response_in_time", rsp_hs, 1);
    endtask

    initial begin
        int   n;
        bit   ids[6];
        logic [3:0] sums[6];

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        model_reset();

        // Reset, then 10 idle cycles
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();

        // Basic transactions with exact latency
        bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd4;
        step();
        chk("t1_accept", acc0, 1);
        bus.req0_valid = 1'b0;
        step();
        step();
        chk("t1_resp_hs", rsp_hs, 1);
        chk("t1_resp", rsp_obs, {1'b0, 4'd7, 1'b0});
        single(1'b1, 4'd15, 4'd1);
        chk("t2_resp", rsp_obs, {1'b1, 4'd0, 1'b1});
        single(1'b1, 4'd9, 4'd9);
        chk("t3_resp", rsp_obs, {1'b1, 4'd2, 1'b1});

        // Continuous contention: grants must alternate starting with requester 0
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd2;
        bus.rsp_ready  = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            step();
            if (rsp_hs) begin
                ids[n]  = rsp_obs.id;
                sums[n] = rsp_obs.sum;
                n++;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("rr_count", n, 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_id%0d", k), ids[k], k % 2);
            chk($sformatf("rr_sum%0d", k), sums[k], (k % 2) ? 4 : 2);
        end
        step();

        // Backpressure: response held, no accept while req1 waits
        bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd6;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd7; bus.req1_b = 4'd8;
        bus.rsp_ready  = 1'b0;
        step();
        chk("bp_accept0", acc0, 1);
        bus.req0_valid = 1'b0;
        repeat (6) step();
        chk("bp_no_hs", rsp_hs, 0);
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_release", rsp_hs, 1);
        chk("bp_resp", rsp_obs, {1'b0, 4'd11, 1'b0});
        bus.req1_valid = 1'b0;
        step();

        // Reset during CALC: dropped transaction, rr pointer back to requester 0
        bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd2;
        step();
        chk("rst_accept", acc0, 1);
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd6; bus.req0_b = 4'd12;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd1; bus.req1_b = 4'd1;
        step();
        chk("rst_first_grant0", acc0, 1);
        bus.req0_valid = 1'b0;
        step();
        step();
        chk("rst_resp", rsp_obs, {1'b0, 4'd2, 1'b1});
        bus.req1_valid = 1'b0;
        repeat (4) step();

        // Exhaustive sweep through requester 0
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                single(1'b0, 4'(a), 4'(b));
            end
        end

        // Random traffic with random backpressure and early valid drops
        for (int i = 0; i < 400; i++) begin
            if (acc0 || !bus.req0_valid) begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req0_a     = 4'($urandom);
                bus.req0_b     = 4'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (acc1 || !bus.req1_valid) begin
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req1_a     = 4'($urandom);
                bus.req1_b     = 4'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req1_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
